// File: rtl/safe_bus_pkg.sv
// Shared types for the bus-redundancy controller: OBI request/response
// structs, the operating-mode and handshake-state enums, and the "no hart" index.
package safe_bus_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    INDEP = 2'd0,
    DMR   = 2'd1,
    TMR   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SYNC,
    SWITCH
  } state_e;

  localparam logic [1:0]  NONE_HART = 2'd3;
  localparam int unsigned NCHAN     = 2;  // channel 0 = instruction, 1 = data

endpackage

// File: rtl/safe_bus_voter.sv
// Generic-width 3-input bitwise majority voter.
// Also reports any disagreement and which single input is the odd one out.
module safe_bus_voter
  import safe_bus_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] maj,
  output logic         mismatch,
  output logic [1:0]   minority
);

  logic eq01, eq02, eq12;

  assign maj      = (in0 & in1) | (in0 & in2) | (in1 & in2);
  assign eq01     = (in0 == in1);
  assign eq02     = (in0 == in2);
  assign eq12     = (in1 == in2);
  assign mismatch = !(eq01 && eq02);

  // With all three different, no single hart can be blamed.
  always_comb begin
    minority = NONE_HART;
    if (eq01 && !eq02)
      minority = 2'd2;
    else if (eq02 && !eq01)
      minority = 2'd1;
    else if (eq12 && !eq01)
      minority = 2'd0;
  end

endmodule

// File: rtl/safe_redundancy_bus_ctrl.sv
// Bus-redundancy controller: INDEP / DMR lockstep / TMR vote with a drain-and-sync mode switch.
// Define SAFE_BUS_TMR_VOTE_EN to compile in the TMR voter and fault_hart_o tracking.
module safe_redundancy_bus_ctrl
  import safe_bus_pkg::*;
#(
  parameter int unsigned NHARTS          = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  obi_req_t          core_instr_req_i  [NHARTS],
  input  obi_req_t          core_data_req_i   [NHARTS],
  output obi_resp_t         core_instr_resp_o [NHARTS],
  output obi_resp_t         core_data_resp_o  [NHARTS],
  output obi_req_t          bus_instr_req_o   [NHARTS],
  output obi_req_t          bus_data_req_o    [NHARTS],
  input  obi_resp_t         bus_instr_resp_i  [NHARTS],
  input  obi_resp_t         bus_data_resp_i   [NHARTS],
  input  logic              mode_req_i,
  input  logic [1:0]        mode_i,
  output logic              mode_ack_o,
  output logic              mode_err_o,
  output logic [1:0]        mode_o,
  input  logic [NHARTS-1:0] sleep_i,
  output logic              sync_irq_o,
  output logic [NHARTS-1:0] halt_o,
  input  logic              err_clr_i,
  output logic              error_o,
  output logic [1:0]        fault_hart_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o
);

  localparam int unsigned    OCW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCW-1:0] OUT_MAX = OCW'(MAX_OUTSTANDING);
`ifdef SAFE_BUS_TMR_VOTE_EN
  localparam bit TMR_OK = (NHARTS >= 3);
`else
  localparam bit TMR_OK = 1'b0;
`endif

  state_e     state_q, state_d;
  mode_e      mode_q;
  logic [1:0] target_q, target_d;
  logic       reject_q, reject_d;
  logic       ack_q, merr_q;
  logic       gate_all, all_idle, mode_bad;
  logic       dmr_mis, mismatch;
  logic       error_q, halt_q;
  logic [CNT_W-1:0] cnt_q;

  obi_req_t   core_req  [NCHAN][NHARTS];
  obi_req_t   bus_req   [NCHAN][NHARTS];
  obi_resp_t  bus_resp  [NCHAN][NHARTS];
  obi_resp_t  core_resp [NCHAN][NHARTS];
  obi_req_t   voted     [NCHAN];
  logic [NCHAN-1:0]             tmr_mis;
  logic [NCHAN-1:0][NHARTS-1:0] port_block;
  logic [OCW-1:0]               out_q [NCHAN][NHARTS];

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      core_req[0][h]       = core_instr_req_i[h];
      core_req[1][h]       = core_data_req_i[h];
      bus_resp[0][h]       = bus_instr_resp_i[h];
      bus_resp[1][h]       = bus_data_resp_i[h];
      core_instr_resp_o[h] = core_resp[0][h];
      core_data_resp_o[h]  = core_resp[1][h];
      bus_instr_req_o[h]   = bus_req[0][h];
      bus_data_req_o[h]    = bus_req[1][h];
    end
  end

  // In the redundant modes only port 0 is live, so every hart sees port 0's response and gating.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      for (int h = 0; h < NHARTS; h++) begin
        port_block[c][h] = gate_all || (out_q[c][h] == OUT_MAX);
      end
      for (int h = 0; h < NHARTS; h++) begin
        bus_req[c][h]   = '0;
        core_resp[c][h] = '0;
        if (mode_q == INDEP) begin
          bus_req[c][h]       = core_req[c][h];
          core_resp[c][h]     = bus_resp[c][h];
          core_resp[c][h].gnt = bus_resp[c][h].gnt & ~port_block[c][h];
        end else begin
          if (h == 0)
            bus_req[c][0] = (mode_q == TMR) ? voted[c] : core_req[c][0];
          core_resp[c][h]     = bus_resp[c][0];
          core_resp[c][h].gnt = bus_resp[c][0].gnt & ~port_block[c][0];
        end
        if (port_block[c][h])
          bus_req[c][h].req = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NCHAN; c++) begin
      for (int h = 0; h < NHARTS; h++) begin
        if (!rst_ni || !(mode_q == INDEP || h == 0))
          out_q[c][h] <= '0;
        else if (bus_req[c][h].req && bus_resp[c][h].gnt && !bus_resp[c][h].rvalid)
          out_q[c][h] <= out_q[c][h] + OCW'(1);
        else if (!(bus_req[c][h].req && bus_resp[c][h].gnt) && bus_resp[c][h].rvalid
                 && out_q[c][h] != '0)
          out_q[c][h] <= out_q[c][h] - OCW'(1);
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    for (int c = 0; c < NCHAN; c++)
      for (int h = 0; h < NHARTS; h++)
        if (out_q[c][h] != '0)
          all_idle = 1'b0;
  end

  assign mode_bad = (mode_i == 2'd3) || (mode_i == 2'd2 && !TMR_OK);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    reject_d   = reject_q;
    gate_all   = (state_q == DRAIN) || (state_q == SYNC);
    sync_irq_o = (state_q == SYNC);
    unique case (state_q)
      RUN: begin
        if (mode_req_i) begin
          target_d = mode_i;
          reject_d = mode_bad;
          if (mode_bad || mode_i == mode_q)
            state_d = SWITCH;
          else
            state_d = DRAIN;
        end
      end
      DRAIN:   if (all_idle) state_d = SYNC;
      SYNC:    if (&sleep_i) state_d = SWITCH;
      SWITCH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      mode_q   <= INDEP;
      target_q <= 2'd0;
      reject_q <= 1'b0;
      ack_q    <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      reject_q <= reject_d;
      ack_q    <= (state_q == SWITCH);
      merr_q   <= (state_q == SWITCH) && reject_q;
      if (state_q == SWITCH && !reject_q)
        mode_q <= mode_e'(target_q);
    end
  end

  // DMR compares whole request structs, but only in cycles where either hart is requesting.
  always_comb begin
    dmr_mis = 1'b0;
    for (int c = 0; c < NCHAN; c++)
      if ((core_req[c][0].req || core_req[c][1].req) && (core_req[c][0] != core_req[c][1]))
        dmr_mis = 1'b1;
    mismatch = (mode_q == DMR) ? dmr_mis : ((mode_q == TMR) ? |tmr_mis : 1'b0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else if (mismatch) begin
      error_q <= 1'b1;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
      if (mode_q == DMR)
        halt_q <= 1'b1;
    end else if (err_clr_i) begin
      error_q <= 1'b0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end
  end

`ifdef SAFE_BUS_TMR_VOTE_EN
  localparam int unsigned REQ_W = $bits(obi_req_t);
  logic [1:0] minority [NCHAN];
  logic [1:0] fault_d, fault_q;

  if (NHARTS >= 3) begin : g_vote
    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
      safe_bus_voter #(.W(REQ_W)) u_voter (
        .in0      (core_req[ch][0]),
        .in1      (core_req[ch][1]),
        .in2      (core_req[ch][2]),
        .maj      (voted[ch]),
        .mismatch (tmr_mis[ch]),
        .minority (minority[ch])
      );
    end
  end else begin : g_novote
    always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
        voted[c]    = core_req[c][0];
        tmr_mis[c]  = 1'b0;
        minority[c] = NONE_HART;
      end
    end
  end

  // Two channels blaming different harts leave no single culprit.
  always_comb begin
    fault_d = NONE_HART;
    if (tmr_mis[0] && tmr_mis[1])
      fault_d = (minority[0] == minority[1]) ? minority[0] : NONE_HART;
    else if (tmr_mis[1])
      fault_d = minority[1];
    else if (tmr_mis[0])
      fault_d = minority[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      fault_q <= NONE_HART;
    else if (mode_q == TMR && mismatch)
      fault_q <= fault_d;
    else if (err_clr_i)
      fault_q <= NONE_HART;
  end

  assign fault_hart_o = fault_q;
`else
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      voted[c]   = core_req[c][0];
      tmr_mis[c] = 1'b0;
    end
  end

  assign fault_hart_o = NONE_HART;
`endif

  assign mode_o         = mode_q;
  assign mode_ack_o     = ack_q;
  assign mode_err_o     = merr_q;
  assign halt_o         = {NHARTS{halt_q}};
  assign error_o        = error_q;
  assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_safe_redundancy_bus_ctrl.sv
// Directed self-checking bench for safe_redundancy_bus_ctrl (NHARTS = 3).
// Covers reset, INDEP routing, outstanding limit, mode handshake, DMR/TMR divergence and reset mid-sync.
module tb_safe_redundancy_bus_ctrl;
  import safe_bus_pkg::*;

  localparam int NH = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  obi_req_t      core_instr_req [NH];
  obi_req_t      core_data_req  [NH];
  obi_resp_t     core_instr_resp[NH];
  obi_resp_t     core_data_resp [NH];
  obi_req_t      bus_instr_req  [NH];
  obi_req_t      bus_data_req   [NH];
  obi_resp_t     bus_instr_resp [NH];
  obi_resp_t     bus_data_resp  [NH];
  logic          mode_req_i, mode_ack_o, mode_err_o, sync_irq_o, err_clr_i, error_o;
  logic [1:0]    mode_i, mode_o, fault_hart_o;
  logic [NH-1:0] sleep_i, halt_o;
  logic [7:0]    mismatch_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  safe_redundancy_bus_ctrl #(.NHARTS(NH), .MAX_OUTSTANDING(4), .CNT_W(8)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .core_instr_req_i  (core_instr_req),
    .core_data_req_i   (core_data_req),
    .core_instr_resp_o (core_instr_resp),
    .core_data_resp_o  (core_data_resp),
    .bus_instr_req_o   (bus_instr_req),
    .bus_data_req_o    (bus_data_req),
    .bus_instr_resp_i  (bus_instr_resp),
    .bus_data_resp_i   (bus_data_resp),
    .mode_req_i        (mode_req_i),
    .mode_i            (mode_i),
    .mode_ack_o        (mode_ack_o),
    .mode_err_o        (mode_err_o),
    .mode_o            (mode_o),
    .sleep_i           (sleep_i),
    .sync_irq_o        (sync_irq_o),
    .halt_o            (halt_o),
    .err_clr_i         (err_clr_i),
    .error_o           (error_o),
    .fault_hart_o      (fault_hart_o),
    .mismatch_cnt_o    (mismatch_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus_idle();
    for (int h = 0; h < NH; h++) begin
      core_instr_req[h] = '0;
      core_data_req[h]  = '0;
      bus_instr_resp[h] = '0;
      bus_data_resp[h]  = '0;
    end
  endtask

  task automatic request_mode(input logic [1:0] m);
    mode_req_i = 1'b1;
    mode_i     = m;
    tick();
    mode_req_i = 1'b0;
  endtask

  initial begin
    apply_stimulus_idle();
    mode_req_i = 1'b0;
    mode_i     = 2'd0;
    sleep_i    = '0;
    err_clr_i  = 1'b0;

    // Reset values
    tick();
    tick();
    check_output("rst_mode", mode_o, 2'd0);
    check_output("rst_ack", mode_ack_o, 1'b0);
    check_output("rst_merr", mode_err_o, 1'b0);
    check_output("rst_irq", sync_irq_o, 1'b0);
    check_output("rst_error", error_o, 1'b0);
    check_output("rst_halt", halt_o, 3'b000);
    check_output("rst_fault", fault_hart_o, 2'd3);
    check_output("rst_cnt", mismatch_cnt_o, 8'd0);
    rst_ni = 1'b1;
    tick();

    // INDEP: three independent reads
    for (int h = 0; h < NH; h++) begin
      core_data_req[h]     = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h100 * (h + 1), wdata: 32'h0};
      bus_data_resp[h].gnt = 1'b1;
    end
    #1;
    check_output("indep_addr0", bus_data_req[0].addr, 32'h100);
    check_output("indep_addr1", bus_data_req[1].addr, 32'h200);
    check_output("indep_addr2", bus_data_req[2].addr, 32'h300);
    check_output("indep_req2", bus_data_req[2].req, 1'b1);
    check_output("indep_gnt1", core_data_resp[1].gnt, 1'b1);
    tick();
    for (int h = 0; h < NH; h++) begin
      core_data_req[h] = '0;
      bus_data_resp[h] = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hA0 + h};
    end
    #1;
    check_output("indep_rdata2", core_data_resp[2].rdata, 32'hA2);
    check_output("indep_rvalid0", core_data_resp[0].rvalid, 1'b1);
    tick();
    apply_stimulus_idle();
    check_output("indep_noerr", error_o, 1'b0);

    // Outstanding limit on hart 1 instruction channel
    core_instr_req[1]      = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0};
    bus_instr_resp[1].gnt  = 1'b1;
    repeat (4) tick();
    check_output("max_out_req", bus_instr_req[1].req, 1'b0);
    check_output("max_out_gnt", core_instr_resp[1].gnt, 1'b0);
    core_instr_req[1]        = '0;
    bus_instr_resp[1]        = '0;
    bus_instr_resp[1].rvalid = 1'b1;
    repeat (4) tick();
    bus_instr_resp[1].rvalid = 1'b0;
    core_instr_req[1].req    = 1'b1;
    bus_instr_resp[1].gnt    = 1'b1;
    #1;
    check_output("max_out_release", bus_instr_req[1].req, 1'b1);
    apply_stimulus_idle();

    // INDEP -> DMR with two reads outstanding on hart 0
    core_data_req[0]     = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h600, wdata: 32'h0};
    bus_data_resp[0].gnt = 1'b1;
    tick();
    tick();
    apply_stimulus_idle();
    request_mode(2'd1);
    core_data_req[0]        = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h700, wdata: 32'h0};
    bus_data_resp[0].gnt    = 1'b1;
    bus_data_resp[0].rvalid = 1'b1;
    #1;
    check_output("drain_req_gated", bus_data_req[0].req, 1'b0);
    check_output("drain_gnt_gated", core_data_resp[0].gnt, 1'b0);
    tick();
    check_output("drain_still_gated", bus_data_req[0].req, 1'b0);
    check_output("drain_irq_low", sync_irq_o, 1'b0);
    tick();
    apply_stimulus_idle();
    check_output("drain_last_irq_low", sync_irq_o, 1'b0);
    tick();
    check_output("sync_irq_high", sync_irq_o, 1'b1);
    sleep_i = 3'b111;
    tick();
    sleep_i = 3'b000;
    check_output("switch_irq_low", sync_irq_o, 1'b0);
    check_output("switch_ack_pending", mode_ack_o, 1'b0);
    tick();
    check_output("dmr_ack", mode_ack_o, 1'b1);
    check_output("dmr_merr", mode_err_o, 1'b0);
    check_output("dmr_mode", mode_o, 2'd1);
    tick();
    check_output("dmr_ack_pulse", mode_ack_o, 1'b0);

    // DMR divergence: hart 0 writes 0xBEEF, hart 1 writes 0xDEAD
    core_data_req[0]       = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h400, wdata: 32'hBEEF};
    core_data_req[1]       = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h400, wdata: 32'hDEAD};
    bus_data_resp[0].rdata = 32'hCAFE;
    bus_data_resp[1].rdata = 32'h1111;
    #1;
    check_output("dmr_port0_wdata", bus_data_req[0].wdata, 32'hBEEF);
    check_output("dmr_port1_zero", bus_data_req[1], '0);
    check_output("dmr_bcast_rdata", core_data_resp[2].rdata, 32'hCAFE);
    check_output("dmr_err_not_yet", error_o, 1'b0);
    tick();
    apply_stimulus_idle();
    check_output("dmr_error", error_o, 1'b1);
    check_output("dmr_cnt1", mismatch_cnt_o, 8'd1);
    check_output("dmr_halt", halt_o, 3'b111);
    core_data_req[0] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h404, wdata: 32'hBEEF};
    core_data_req[1] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h404, wdata: 32'hDEAD};
    err_clr_i        = 1'b1;
    tick();
    apply_stimulus_idle();
    err_clr_i = 1'b0;
    check_output("clr_vs_mis_error", error_o, 1'b1);
    check_output("clr_vs_mis_cnt", mismatch_cnt_o, 8'd2);
    check_output("clr_vs_mis_halt", halt_o, 3'b111);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check_output("clr_error", error_o, 1'b0);
    check_output("clr_cnt", mismatch_cnt_o, 8'd0);
    check_output("clr_halt", halt_o, 3'b000);
    core_data_req[0] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h408, wdata: 32'h5A5A};
    core_data_req[1] = core_data_req[0];
    tick();
    apply_stimulus_idle();
    check_output("dmr_agree_noerr", error_o, 1'b0);

    // Same-mode and illegal-mode requests
    request_mode(2'd1);
    check_output("same_ack_pending", mode_ack_o, 1'b0);
    tick();
    check_output("same_ack", mode_ack_o, 1'b1);
    check_output("same_merr", mode_err_o, 1'b0);
    check_output("same_mode", mode_o, 2'd1);
    request_mode(2'd3);
    tick();
    check_output("ill_ack", mode_ack_o, 1'b1);
    check_output("ill_merr", mode_err_o, 1'b1);
    check_output("ill_mode", mode_o, 2'd1);

`ifdef SAFE_BUS_TMR_VOTE_EN
    // DMR -> TMR, then hart 2 address bit 4 flipped
    request_mode(2'd2);
    tick();
    check_output("tmr_sync_irq", sync_irq_o, 1'b1);
    sleep_i = 3'b111;
    tick();
    sleep_i = 3'b000;
    tick();
    check_output("tmr_ack", mode_ack_o, 1'b1);
    check_output("tmr_merr", mode_err_o, 1'b0);
    check_output("tmr_mode", mode_o, 2'd2);
    core_data_req[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h500, wdata: 32'h0};
    core_data_req[1] = core_data_req[0];
    core_data_req[2] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h510, wdata: 32'h0};
    #1;
    check_output("tmr_vote_addr", bus_data_req[0].addr, 32'h500);
    tick();
    apply_stimulus_idle();
    check_output("tmr_fault", fault_hart_o, 2'd2);
    check_output("tmr_error", error_o, 1'b1);
    check_output("tmr_cnt", mismatch_cnt_o, 8'd1);
    check_output("tmr_no_halt", halt_o, 3'b000);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check_output("tmr_fault_clr", fault_hart_o, 2'd3);
`else
    // TMR unavailable in this build
    request_mode(2'd2);
    tick();
    check_output("notmr_ack", mode_ack_o, 1'b1);
    check_output("notmr_merr", mode_err_o, 1'b1);
    check_output("notmr_mode", mode_o, 2'd1);
    check_output("notmr_fault", fault_hart_o, 2'd3);
`endif

    // Reset during SYNC
    tick();
    request_mode(2'd0);
    tick();
    check_output("pre_rst_sync", sync_irq_o, 1'b1);
    rst_ni = 1'b0;
    tick();
    check_output("rst_sync_mode", mode_o, 2'd0);
    check_output("rst_sync_irq", sync_irq_o, 1'b0);
    core_data_req[0]     = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h800, wdata: 32'h0};
    bus_data_resp[0].gnt = 1'b1;
    #1;
    check_output("rst_sync_ungated_req", bus_data_req[0].req, 1'b1);
    check_output("rst_sync_ungated_gnt", core_data_resp[0].gnt, 1'b1);
    apply_stimulus_idle();
    rst_ni = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
